muldiv_unit: RTL

Iterative RV32M multiply/divide unit in the execute stage. Consumes the decoded `muldiv_funct3_t` operation and two register operands when the control word's `muldiv_mask` is set. Holds the pipeline via `busy` while it works, then returns one 32-bit result with a single-cycle `done` pulse to the execute-stage result mux.

---
 rtl/rv32i_types.sv | 28 ++
 rtl/muldiv_datapath.sv | 124 ++++++++++++
 rtl/muldiv_unit.sv | 81 ++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32 type package: M-extension operation encodings and the muldiv FSM states.
package rv32i_types;

  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'b000,
    MULDIV_MULH   = 3'b001,
    MULDIV_MULHSU = 3'b010,
    MULDIV_MULHU  = 3'b011,
    MULDIV_DIV    = 3'b100,
    MULDIV_DIVU   = 3'b101,
    MULDIV_REM    = 3'b110,
    MULDIV_REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;

  // Two's-complement magnitude of a 32-bit value when it is treated as signed and negative.
  function automatic logic [31:0] muldiv_mag(input logic [31:0] val, input logic is_neg);
    return is_neg ? 32'(-val) : val;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath with sign fix-up, steered by muldiv_unit.
// MULDIV_FAST_MUL_EN: multiplies load a full signed product at start and skip iteration.
module muldiv_datapath
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            fix_we,
  input  muldiv_funct3_t  funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            skip_calc,
  output logic [XLEN-1:0] result
);

  logic [63:0]    acc_q, acc_d;
  logic [31:0]    b_q, b_d;
  logic           neg_q, neg_d;
  muldiv_funct3_t funct3_q, funct3_d;
  logic [31:0]    result_q, result_d;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic        is_div, is_rem, div_zero, div_ovf, early_out, fast_mul;
  logic [31:0] a_mag, b_mag;
  logic [63:0] fast_prod;
  logic [32:0] mul_sum, rem_shift, trial;
  logic [63:0] acc_fixed;
  logic [31:0] quo_fixed, rem_fixed;

  always_comb begin
    a_signed  = funct3 inside {MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
    b_signed  = funct3 inside {MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
    a_neg     = a_signed & op_a[31];
    b_neg     = b_signed & op_b[31];
    a_mag     = muldiv_mag(op_a, a_neg);
    b_mag     = muldiv_mag(op_b, b_neg);
    is_div    = funct3[2];
    is_rem    = funct3[2] & funct3[1];
    div_zero  = is_div && (op_b == 32'd0);
    div_ovf   = is_div && b_signed && (op_a == 32'h8000_0000) && (&op_b);
    early_out = div_zero | div_ovf;
    // Sign-extended operands give the exact signed 33x33 product in the low 64 bits.
    fast_prod = {{32{a_neg}}, op_a} * {{32{b_neg}}, op_b};
`ifdef MULDIV_FAST_MUL_EN
    fast_mul  = ~is_div;
`else
    fast_mul  = 1'b0;
`endif
    skip_calc = early_out | fast_mul;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? b_q : 32'd0)};
    rem_shift = {acc_q[63:32], acc_q[31]};
    trial     = rem_shift - {1'b0, b_q};
    acc_fixed = neg_q ? 64'(-acc_q) : acc_q;
    quo_fixed = neg_q ? 32'(-acc_q[31:0]) : acc_q[31:0];
    rem_fixed = neg_q ? 32'(-acc_q[63:32]) : acc_q[63:32];
  end

  // Early-out cases preload the register so the normal fix-up yields the architected result.
  always_comb begin
    acc_d    = acc_q;
    b_d      = b_q;
    neg_d    = neg_q;
    funct3_d = funct3_q;
    result_d = result_q;
    if (load) begin
      funct3_d = funct3;
      b_d      = b_mag;
      if (div_zero) begin
        acc_d = {op_a, 32'hFFFF_FFFF};
        neg_d = 1'b0;
      end else if (div_ovf) begin
        acc_d = {32'd0, 32'h8000_0000};
        neg_d = 1'b0;
      end else if (fast_mul) begin
        acc_d = fast_prod;
        neg_d = 1'b0;
      end else begin
        acc_d = {32'd0, a_mag};
        neg_d = is_rem ? a_neg : (a_neg ^ b_neg);
      end
    end else if (step) begin
      if (funct3_q[2]) begin
        acc_d = trial[32] ? {rem_shift[31:0], acc_q[30:0], 1'b0}
                          : {trial[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_d = {mul_sum, acc_q[31:1]};
      end
    end
    if (fix_we) begin
      case (funct3_q)
        MULDIV_MUL:                              result_d = acc_fixed[31:0];
        MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: result_d = acc_fixed[63:32];
        MULDIV_DIV, MULDIV_DIVU:                 result_d = quo_fixed;
        default:                                 result_d = rem_fixed;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      funct3_q <= MULDIV_MUL;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      funct3_q <= funct3_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: IDLE/CALC/FIX control around muldiv_datapath.
// MULDIV_FAST_MUL_EN (in muldiv_datapath) lets multiplies bypass CALC.
module muldiv_unit
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_t state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          load, step, fix_we, skip_calc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Flush overrides everything, including a start arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = (state_q == FIX) && !flush;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          cnt_d   = '0;
          state_d = skip_calc ? FIX : CALC;
        end
        CALC: begin
          cnt_d = 5'(cnt_q + 5'd1);
          if (cnt_q == 5'(MULDIV_ITERS - 1)) state_d = FIX;
        end
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q != IDLE);
    done   = done_q;
    load   = (state_q == IDLE) && start && !flush;
    step   = (state_q == CALC) && !flush;
    fix_we = (state_q == FIX) && !flush;
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .fix_we    (fix_we),
    .funct3    (muldiv_funct3_t'(funct3)),
    .op_a      (op_a),
    .op_b      (op_b),
    .skip_calc (skip_calc),
    .result    (result)
  );

endmodule
